// File: rtl/aqua_mem_responder.sv
// Single-port word-addressed memory target with a fixed, parameterised busy latency.
// Accepts one request in IDLE, holds busy for LATENCY cycles, then commits or returns data.
module aqua_mem_responder #(
  parameter int MEM_DATA_WIDTH = 32,
  parameter int MEM_ADDR_WIDTH = 32,
  parameter int DEPTH_WORDS    = 1024,
  parameter int LATENCY        = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      memReq,
  input  logic                      memWr,
  input  logic [MEM_ADDR_WIDTH-1:0] memAddr,
  input  logic [MEM_DATA_WIDTH-1:0] memDataIn,
  output logic                      memBusyOut,
  output logic [MEM_DATA_WIDTH-1:0] memDataOut,
  output logic                      memRespValid,
  output logic                      memErr
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  if (LATENCY < 1) begin : g_bad_latency
    $error("aqua_mem_responder: LATENCY must be >= 1");
  end
  if ((1 << IDX_W) != DEPTH_WORDS) begin : g_bad_depth
    $error("aqua_mem_responder: DEPTH_WORDS must be a power of two");
  end

  typedef enum logic {IDLE, WAIT} state_t;

  state_t                    state, next_state;
  logic                      accept, complete;
  logic [CNT_W-1:0]          cnt;
  logic                      wr_q, oor_q;
  logic [IDX_W-1:0]          idx_q;
  logic [MEM_DATA_WIDTH-1:0] data_q;
  logic [MEM_DATA_WIDTH-1:0] ram [DEPTH_WORDS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: if (memReq) begin
        accept     = 1'b1;
        next_state = WAIT;
      end
      WAIT: if (cnt == '0) begin
        complete   = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign memBusyOut = (state == WAIT);

  // Range decision is taken at accept time so completion only needs the latched flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt          <= '0;
      wr_q         <= 1'b0;
      oor_q        <= 1'b0;
      idx_q        <= '0;
      data_q       <= '0;
      memDataOut   <= '0;
      memRespValid <= 1'b0;
      memErr       <= 1'b0;
    end else begin
      memRespValid <= complete;
      memErr       <= complete & oor_q;
      if (accept) begin
        cnt    <= CNT_W'(LATENCY - 1);
        wr_q   <= memWr;
        oor_q  <= (memAddr >> 2) >= MEM_ADDR_WIDTH'(DEPTH_WORDS);
        idx_q  <= memAddr[2 +: IDX_W];
        data_q <= memDataIn;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (complete && !wr_q) begin
        memDataOut <= oor_q ? '0 : ram[idx_q];
      end
    end
  end

  // RAM contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (complete && wr_q && !oor_q) ram[idx_q] <= data_q;
  end

endmodule

// File: tb/tb_aqua_mem_responder.sv
// Directed bench for aqua_mem_responder: table-driven accesses at LATENCY=2
// plus hand-written reset, busy-ignore, held-request and LATENCY=1 back-to-back sequences.
module tb_aqua_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req, wr, busy, valid, err;
  logic [31:0] addr, din, dout;
  logic        req1, wr1, busy1, valid1, err1;
  logic [31:0] addr1, din1, dout1;

  int tests = 0;
  int fails = 0;

  aqua_mem_responder #(
    .MEM_DATA_WIDTH(32), .MEM_ADDR_WIDTH(32), .DEPTH_WORDS(1024), .LATENCY(2)
  ) dut (
    .clk(clk), .reset(rst_n), .memReq(req), .memWr(wr), .memAddr(addr),
    .memDataIn(din), .memBusyOut(busy), .memDataOut(dout),
    .memRespValid(valid), .memErr(err)
  );

  aqua_mem_responder #(
    .MEM_DATA_WIDTH(32), .MEM_ADDR_WIDTH(32), .DEPTH_WORDS(1024), .LATENCY(1)
  ) dut1 (
    .clk(clk), .reset(rst_n), .memReq(req1), .memWr(wr1), .memAddr(addr1),
    .memDataIn(din1), .memBusyOut(busy1), .memDataOut(dout1),
    .memRespValid(valid1), .memErr(err1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One complete access on the LATENCY=2 instance with the request dropped after acceptance.
  task automatic run_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] exp_d, input logic exp_e, input string tag);
    int n;
    int nb;
    @(negedge clk);
    req = 1'b1; wr = w; addr = a; din = d;
    @(negedge clk);
    req = 1'b0; wr = 1'b0; addr = 32'hFFFF_FFFC; din = 32'h0BAD_F00D;
    n = 0; nb = 0;
    while (!valid && n < 20) begin
      if (busy) nb++;
      @(negedge clk);
      n++;
    end
    check({tag, ".valid"}, 32'(valid), 32'd1);
    check({tag, ".busy_cycles"}, 32'(nb), 32'd2);
    check({tag, ".busy_done"}, 32'(busy), 32'd0);
    check({tag, ".err"}, 32'(err), 32'(exp_e));
    check({tag, ".data"}, dout, exp_d);
    @(negedge clk);
    check({tag, ".valid_pulse"}, 32'(valid), 32'd0);
    check({tag, ".err_pulse"}, 32'(err), 32'd0);
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_d;
    logic        exp_e;
  } vec_t;

  vec_t        vecs [10];
  logic [31:0] sb [8];

  initial begin
    int n;
    vecs[0] = '{1'b1, 32'h10,   32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[1] = '{1'b0, 32'h10,   32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[2] = '{1'b1, 32'h21,   32'h1234_5678, 32'hDEAD_BEEF, 1'b0};
    vecs[3] = '{1'b0, 32'h20,   32'h0,         32'h1234_5678, 1'b0};
    vecs[4] = '{1'b1, 32'h00,   32'hA5A5_A5A5, 32'h1234_5678, 1'b0};
    vecs[5] = '{1'b1, 32'h1000, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1};
    vecs[6] = '{1'b0, 32'h1000, 32'h0,         32'h0000_0000, 1'b1};
    vecs[7] = '{1'b0, 32'h00,   32'h0,         32'hA5A5_A5A5, 1'b0};
    vecs[8] = '{1'b1, 32'h14,   32'h5555_5555, 32'hA5A5_A5A5, 1'b0};
    vecs[9] = '{1'b0, 32'h14,   32'h0,         32'h5555_5555, 1'b0};
    for (int i = 0; i < 8; i++) sb[i] = 32'hA000_0010 + 32'(i) * 32'h0101_0101;

    rst_n = 1'b0;
    req = 1'b0; wr = 1'b0; addr = '0; din = '0;
    req1 = 1'b0; wr1 = 1'b0; addr1 = '0; din1 = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.data", dout, 32'd0);
    check("reset.valid", 32'(valid), 32'd0);
    check("reset.err", 32'(err), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++)
      run_access(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].exp_d, vecs[i].exp_e,
                 $sformatf("vec%0d", i));

    // Reset in the middle of a write to word 5: outputs clear at once, write is abandoned.
    @(negedge clk);
    req = 1'b1; wr = 1'b1; addr = 32'h14; din = 32'hBAD0_BAD0;
    @(negedge clk);
    req = 1'b0;
    check("rst_mid.busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid.busy", 32'(busy), 32'd0);
    check("rst_mid.data", dout, 32'd0);
    check("rst_mid.valid", 32'(valid), 32'd0);
    check("rst_mid.err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_access(1'b0, 32'h14, 32'h0, 32'h5555_5555, 1'b0, "rst_mid.read5");

    // Request/address churn during WAIT must not alter or queue anything.
    @(negedge clk);
    req = 1'b1; wr = 1'b1; addr = 32'h30; din = 32'h1111_1111;
    @(negedge clk);
    req = 1'b0; wr = 1'b0; addr = 32'h34; din = 32'h2222_2222;
    @(negedge clk);
    req = 1'b1; wr = 1'b1; addr = 32'h38; din = 32'h3333_3333;
    @(negedge clk);
    check("ignore.valid", 32'(valid), 32'd1);
    check("ignore.err", 32'(err), 32'd0);
    check("ignore.data_held", dout, 32'h5555_5555);
    req = 1'b0; wr = 1'b0;
    @(negedge clk);
    check("ignore.no_queue", 32'(busy), 32'd0);
    run_access(1'b0, 32'h30, 32'h0, 32'h1111_1111, 1'b0, "ignore.read");

    // Request held through the response cycle is accepted at the next edge.
    @(negedge clk);
    req = 1'b1; wr = 1'b1; addr = 32'h40; din = 32'h0000_0077;
    n = 0;
    do begin @(negedge clk); n++; end while (!valid && n < 20);
    check("held.first_valid", 32'(valid), 32'd1);
    check("held.first_latency", 32'(n), 32'd3);
    check("held.idle_in_resp", 32'(busy), 32'd0);
    wr = 1'b0;
    @(negedge clk);
    check("held.second_started", 32'(busy), 32'd1);
    req = 1'b0;
    n = 0;
    while (!valid && n < 20) begin @(negedge clk); n++; end
    check("held.second_valid", 32'(valid), 32'd1);
    check("held.second_data", dout, 32'h0000_0077);
    check("held.second_err", 32'(err), 32'd0);

    // LATENCY=1 instance: request held high, one access per two cycles.
    @(negedge clk);
    req1 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr1   = (i < 8);
      addr1 = 32'((i % 8) * 4);
      din1  = (i < 8) ? sb[i % 8] : 32'hDEAD_0000;
      n = 0;
      do begin @(negedge clk); n++; end while (!valid1 && n < 10);
      check($sformatf("b2b%0d.spacing", i), 32'(n), 32'd2);
      check($sformatf("b2b%0d.err", i), 32'(err1), 32'd0);
      if (i >= 8) check($sformatf("b2b%0d.data", i), dout1, sb[i % 8]);
    end
    req1 = 1'b0;
    @(negedge clk);
    check("b2b.idle_after", 32'(busy1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
